// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among NUM_REQ
// writeback units, plus a per-register busy scoreboard for RAW hazard checks.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  input  logic [ADDR_W-1:0]         check_addrA,
  input  logic [ADDR_W-1:0]         check_addrB,
  output logic                      hazardA,
  output logic                      hazardB,
  output logic [(1<<ADDR_W)-1:0]    busy_mask
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [PTR_W-1:0]    cand;
  logic [PTR_W:0]      sum;
  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy_next;

  // Handshake: requester i transfers at a rising edge where req_valid[i] and
  // req_ready[i] are both 1. Ready depends only on the valids and rr_ptr, so a
  // requester may hold valid waiting for ready but must not wait for ready to
  // raise valid.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_grant = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!any_grant && req_valid[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        win_idx     = cand;
      end
    end
    if (rst) begin
      grant     = '0;
      any_grant = 1'b0;
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr  = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
  assign req_ready = grant;

  // A reservation at the same edge as the committing write wins: the newer
  // producer is still outstanding.
  always_comb begin
    busy_next = busy_mask;
    if (wr_en) busy_next[wr_addr] = 1'b0;
    if (reserve_valid) busy_next[reserve_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy_mask <= '0;
    end else begin
      wr_en     <= any_grant;
      busy_mask <= busy_next;
      if (any_grant) begin
        wr_addr <= win_addr;
        wr_data <= win_data;
        rr_ptr  <= next_ptr;
      end
    end
  end

  assign hazardA = busy_mask[check_addrA];
  assign hazardB = busy_mask[check_addrB];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: arbitration order, write-port
// timing, scoreboard lifecycle, collisions and asynchronous reset.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        reserve_valid;
  logic [4:0]  reserve_addr;
  logic [4:0]  check_addrA;
  logic [4:0]  check_addrB;
  logic        hazardA;
  logic        hazardB;
  logic [31:0] busy_mask;

  int errors = 0;
  int checks = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .check_addrA(check_addrA), .check_addrB(check_addrB),
    .hazardA(hazardA), .hazardB(hazardB), .busy_mask(busy_mask)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  exp_rdy [6];
    logic [4:0]  exp_adr [6];
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    reserve_valid = 1'b0;
    reserve_addr  = '0;
    check_addrA   = '0;
    check_addrB   = '0;

    // reset then idle
    edge_step();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    req_valid = 3'b111;
    #1;
    chk("rst_ready_gated", 64'(req_ready), 64'd0);
    edge_step();
    chk("rst_wr_en2", 64'(wr_en), 64'd0);
    req_valid = 3'b000;
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(req_ready), 64'd0);
    edge_step();
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_busy", 64'(busy_mask), 64'd0);
    chk("idle_hazA", 64'(hazardA), 64'd0);

    // single request from requester 0
    req_valid = 3'b001; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    #1;
    chk("single_ready", 64'(req_ready), 64'b001);
    edge_step();
    req_valid = 3'b000;
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    edge_step();
    chk("single_wr_en_off", 64'(wr_en), 64'd0);
    chk("single_addr_hold", 64'(wr_addr), 64'd5);
    chk("single_data_hold", 64'(wr_data), 64'hDEADBEEF);

    // pointer is at 1: a lone request from 2 wins, pointer wraps to 0
    req_valid = 3'b100; a[2] = 5'd3; d[2] = 32'h0000_0033;
    #1;
    chk("lone2_ready", 64'(req_ready), 64'b100);
    edge_step();
    chk("lone2_wr_addr", 64'(wr_addr), 64'd3);
    chk("lone2_wr_data", 64'(wr_data), 64'h33);

    // round-robin with all three valid
    a[0] = 5'd10; a[1] = 5'd11; a[2] = 5'd12;
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
    req_valid = 3'b111;
    exp_rdy = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_adr = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(exp_rdy[i]));
      edge_step();
      chk($sformatf("rr_wr_en_%0d", i), 64'(wr_en), 64'd1);
      chk($sformatf("rr_wr_addr_%0d", i), 64'(wr_addr), 64'(exp_adr[i]));
      chk($sformatf("rr_wr_data_%0d", i), 64'(wr_data), 64'(32'hA0 + 32'(i % 3)));
    end

    // skip idle requester 1: 0, 2, 0
    req_valid = 3'b101;
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b100; exp_rdy[2] = 3'b001;
    exp_adr[0] = 5'd10;  exp_adr[1] = 5'd12;  exp_adr[2] = 5'd10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("skip_ready_%0d", i), 64'(req_ready), 64'(exp_rdy[i]));
      edge_step();
      chk($sformatf("skip_wr_addr_%0d", i), 64'(wr_addr), 64'(exp_adr[i]));
    end
    req_valid = 3'b000;
    edge_step();
    chk("skip_wr_en_off", 64'(wr_en), 64'd0);

    // scoreboard lifecycle on register 7 (pointer now at 1)
    reserve_valid = 1'b1; reserve_addr = 5'd7;
    check_addrA = 5'd7; check_addrB = 5'd8;
    edge_step();
    reserve_valid = 1'b0;
    chk("sb_hazA_t", 64'(hazardA), 64'd1);
    chk("sb_hazB_t", 64'(hazardB), 64'd0);
    chk("sb_busy_t", 64'(busy_mask), 64'h80);
    edge_step();
    chk("sb_hazA_t1", 64'(hazardA), 64'd1);
    edge_step();
    req_valid = 3'b001; a[0] = 5'd7; d[0] = 32'h77;
    #1;
    chk("sb_ready", 64'(req_ready), 64'b001);
    chk("sb_hazA_t2", 64'(hazardA), 64'd1);
    edge_step();
    req_valid = 3'b000;
    chk("sb_wr_en", 64'(wr_en), 64'd1);
    chk("sb_wr_addr", 64'(wr_addr), 64'd7);
    chk("sb_hazA_t3", 64'(hazardA), 64'd1);
    edge_step();
    chk("sb_hazA_t4", 64'(hazardA), 64'd0);
    chk("sb_busy_t4", 64'(busy_mask), 64'd0);
    chk("sb_wr_en_off", 64'(wr_en), 64'd0);

    // collision: reserve and commit reg 9 at the same edge (pointer at 1)
    reserve_valid = 1'b1; reserve_addr = 5'd9;
    req_valid = 3'b010; a[1] = 5'd9; d[1] = 32'h99;
    check_addrB = 5'd9;
    #1;
    chk("col_ready", 64'(req_ready), 64'b010);
    edge_step();
    req_valid = 3'b000;
    chk("col_wr_addr", 64'(wr_addr), 64'd9);
    chk("col_busy_pre", 64'(busy_mask), 64'h200);
    edge_step();
    reserve_valid = 1'b0;
    chk("col_busy_set_wins", 64'(busy_mask), 64'h200);
    chk("col_hazB", 64'(hazardB), 64'd1);

    // async reset while a write is in flight and busy_mask=0x280 (pointer at 2)
    reserve_valid = 1'b1; reserve_addr = 5'd7;
    req_valid = 3'b100; a[2] = 5'd1; d[2] = 32'h11;
    #1;
    chk("ar_ready", 64'(req_ready), 64'b100);
    edge_step();
    reserve_valid = 1'b0;
    req_valid = 3'b000;
    chk("ar_wr_en_pre", 64'(wr_en), 64'd1);
    chk("ar_busy_pre", 64'(busy_mask), 64'h280);
    chk("ar_hazA_pre", 64'(hazardA), 64'd1);
    #2;
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    chk("ar_wr_en", 64'(wr_en), 64'd0);
    chk("ar_busy", 64'(busy_mask), 64'd0);
    chk("ar_hazA", 64'(hazardA), 64'd0);
    chk("ar_hazB", 64'(hazardB), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    chk("ar_wr_addr", 64'(wr_addr), 64'd0);
    edge_step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b001);
    edge_step();
    req_valid = 3'b000;
    chk("post_rst_wr_data", 64'(wr_data), 64'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
